// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: FIFO-buffers bundles, issues one at a time,
// captures result/flags after a settle cycle and presents them with decoded write-back dest.
// Optional ALU_ISSUE_STATS_EN adds stat_issued / stat_stall counters.
module alu_issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_reg_A,
  output logic [31:0] alu_reg_B,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [4:0]  out_dest,
  output logic        out_wr_en,
  output logic        busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stall
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } bundle_t;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  bundle_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop, cap, rel;
  state_t        state_q, state_d;
  logic [4:0]    dec_dest;
  logic          dec_wr;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state_q != IDLE) || !empty;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        cap     = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          rel     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Branches and stores have no destination; forcing dest=0 also clears wr_en below.
  always_comb begin
    dec_dest = alu_instr[20:16];
    case (alu_instr[31:26])
      6'b000000:                      dec_dest = alu_instr[15:11];
      6'b000100, 6'b000101, 6'b101011: dec_dest = 5'd0;
      default: ;
    endcase
    dec_wr = (dec_dest != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, op_a: in_op_a, op_b: in_op_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_instr <= '0;
      alu_reg_A <= '0;
      alu_reg_B <= '0;
    end else if (pop) begin
      alu_instr <= mem[rd_ptr].instr;
      alu_reg_A <= mem[rd_ptr].op_a;
      alu_reg_B <= mem[rd_ptr].op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_dest   <= '0;
      out_wr_en  <= 1'b0;
    end else if (cap) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_flags  <= alu_flags;
      out_dest   <= dec_dest;
      out_wr_en  <= dec_wr;
    end else if (rel) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (pop) stat_issued <= stat_issued + 32'd1;
      if (state_q == HOLD && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the alu_* ports, queue-based reference
// model of issued results, directed scenarios followed by a randomized phase.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_op_a, in_op_b;
  logic [31:0] alu_instr, alu_reg_A, alu_reg_B, alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [4:0]  out_dest;
  logic        out_wr_en, busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .alu_instr(alu_instr), .alu_reg_A(alu_reg_A), .alu_reg_B(alu_reg_B),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Behavioural ALU: flags = {zero, negative, signed overflow}
  function automatic logic [34:0] alu_fn(input logic [31:0] i, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] imm, r;
    logic ovf;
    imm = {{16{i[15]}}, i[15:0]};
    ovf = 1'b0;
    r   = a + imm;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h22, 6'h23: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = {31'b0, ($signed(a) < $signed(b))};
        default: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      endcase
      6'h04, 6'h05: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      6'h0c: r = a & {16'b0, i[15:0]};
      6'h0d: r = a | {16'b0, i[15:0]};
      6'h0e: r = a ^ {16'b0, i[15:0]};
      6'h0f: r = {i[15:0], 16'b0};
      default: begin r = a + imm; ovf = (a[31] == imm[31]) && (r[31] != a[31]); end
    endcase
    return {(r == 32'b0), r[31], ovf, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_instr, alu_reg_A, alu_reg_B);

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic [4:0]  dest;
    logic        wr;
  } exp_t;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [34:0] r;
    r = alu_fn(i, a, b);
    e.res = r[31:0];
    e.flg = r[34:32];
    if (i[31:26] == 6'h00) e.dest = i[15:11];
    else if (i[31:26] == 6'h04 || i[31:26] == 6'h05 || i[31:26] == 6'h2b) e.dest = 5'd0;
    else e.dest = i[20:16];
    e.wr = (e.dest != 5'd0);
    return e;
  endfunction

  exp_t q[$];
  int   n_assert = 0, n_fail = 0, n_out = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes and pushes against the model, check HOLD stability.
  task automatic tick();
    exp_t e;
    logic        hold;
    logic [31:0] h_res;
    logic [2:0]  h_flg;
    logic [4:0]  h_dst;
    logic        h_wr;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_flags", {29'b0, out_flags}, {29'b0, e.flg});
          chk("out_dest", {27'b0, out_dest}, {27'b0, e.dest});
          chk("out_wr_en", {31'b0, out_wr_en}, {31'b0, e.wr});
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_instr, in_op_a, in_op_b));
    end
    hold  = !rst && out_valid && !out_ready;
    h_res = out_result; h_flg = out_flags; h_dst = out_dest; h_wr = out_wr_en;
    @(posedge clk); #1;
    if (hold) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", out_result, h_res);
      chk("hold_misc", {23'b0, out_flags, out_dest, out_wr_en}, {23'b0, h_flg, h_dst, h_wr});
    end
  endtask

  task automatic push1(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_instr = i; in_op_a = a; in_op_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) chk("timeout_valid", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 1000) begin tick(); n++; end
    chk("drain_queue", q.size(), 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic rand_bundle();
    logic [5:0] ops [12];
    logic [5:0] fns [8];
    logic [31:0] r;
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};
    fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    r = $urandom();
    if ($urandom_range(0, 3) == 0) r[15:11] = 5'd0;
    if ($urandom_range(0, 3) == 0) r[20:16] = 5'd0;
    r[31:26] = ops[$urandom_range(0, 11)];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 7)];
    in_instr = r;
    in_op_a  = $urandom();
    in_op_b  = ($urandom_range(0, 3) == 0) ? in_op_a : $urandom();
  endtask

  initial begin
    int lat, n0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_op_a = '0; in_op_b = '0;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_alu_instr", alu_instr, 32'd0);
    chk("rst_alu_ops", alu_reg_A | alu_reg_B, 32'd0);
    chk("rst_out_bits", {out_result[25:0], out_flags, out_dest[1:0], out_wr_en}, 32'd0);
    rst = 1'b0;

    // add, overflowing to zero; latency from push
    out_ready = 1'b1;
    push1(32'h00205820, 32'h80000000, 32'h80000000);
    wait_valid(lat);
    chk("t1_latency", lat + 1, 32'd4);
    chk("t1_result", out_result, 32'h0);
    chk("t1_dest", {27'b0, out_dest}, 32'd11);
    chk("t1_wr_en", {31'b0, out_wr_en}, 32'd1);
    tick();

    // addi with rt=$zero: never written
    push1(32'h20000014, 32'h02020402, 32'h0);
    wait_valid(lat);
    chk("t2_result", out_result, 32'h02020416);
    chk("t2_dest", {27'b0, out_dest}, 32'd0);
    chk("t2_wr_en", {31'b0, out_wr_en}, 32'd0);
    tick();

    // beq then sw back to back, results in push order
    in_valid = 1'b1; in_instr = 32'h1020000A; in_op_a = 32'd5; in_op_b = 32'd5;
    tick();
    in_instr = 32'hAC080008; in_op_a = 32'h100; in_op_b = 32'h77;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("t3_first_result", out_result, 32'h0);
    chk("t3_first_wr_en", {31'b0, out_wr_en}, 32'd0);
    tick();
    wait_valid(lat);
    chk("t3_second_result", out_result, 32'h108);
    chk("t3_second_wr_en", {31'b0, out_wr_en}, 32'd0);
    tick();
    drain();

    // fill: one in flight plus a full FIFO; extra push refused
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; rand_bundle(); tick();
    end
    chk("t4_full_in_ready", {31'b0, in_ready}, 32'd0);
    rand_bundle(); tick();
    chk("t4_still_full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t4_drained_count", n_out - n0, 32'd9);

    // HOLD stall with stable outputs
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    rand_bundle(); push1(in_instr, in_op_a, in_op_b);
    wait_valid(lat);
    repeat (5) tick();
`ifdef ALU_ISSUE_STATS_EN
    chk("t5_stat_stall", stat_stall, 32'd5);
    chk("t5_stat_issued", stat_issued, 32'd1);
`endif
    out_ready = 1'b1;
    drain();

    // reset while a bundle is settling with 3 queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; rand_bundle(); tick();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    chk("t6_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6_alu_instr", alu_instr, 32'd0);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (20) tick();
    chk("t6_no_stale", n_out - n0, 32'd0);

    // randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_bundle();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
